router_input_port: RTL and testbench

Parametrised input-port unit for the next-generation Phoenix NoC router: one per router port, replacing the fixed-width input buffer and per-port slice of the centralised switch control. It buffers incoming flits under credit-based flow control, decodes the packet header, and computes the XY output port. It then requests a connection from the switch allocator and streams the packet through the crossbar, releasing the connection on the last flit. Flit width, buffer depth, coordinate width and local address are parameters.

---
 rtl/router_input_port.sv | 165 ++++++++++++++++
 tb/tb_router_input_port.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_port.sv
// Phoenix NoC router input port: credit-flow flit buffer, XY route,
// switch request and packet streaming with release on the last flit.
module router_input_port #(
  parameter int FLIT_W  = 16,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  input  logic [FLIT_W-1:0] i_data,
  output logic              o_credit,
  output logic              o_req,
  output logic [4:0]        o_port,
  input  logic              i_grant,
  output logic              o_data_av,
  output logic [FLIT_W-1:0] o_data,
  input  logic              i_data_ack,
  output logic              o_release,
  output logic              o_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] LX = ADDR_W'(LOCAL_X);
  localparam logic [ADDR_W-1:0] LY = ADDR_W'(LOCAL_Y);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER
  } state_t;

  typedef enum logic [1:0] {
    P_HDR,
    P_SIZE,
    P_PAY
  } phase_t;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [FLIT_W-1:0] rem_q, rem_d;
  logic [4:0]        port_q, port_d;
  logic              rel_q, rel_d;
  logic              ovf_q, ovf_d;

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] tx;
  logic [ADDR_W-1:0] ty;
  logic [4:0]        route;

  assign o_credit  = cnt_q < FULL;
  assign push      = i_rx & o_credit;
  assign o_data    = mem_q[rd_ptr_q];
  assign o_data_av = (state_q == S_XFER) && (cnt_q != '0);
  assign pop       = o_data_av & i_data_ack;
  assign o_req     = state_q == S_REQ;
  assign o_port    = port_q;
  assign o_release = rel_q;
  assign o_ovf     = ovf_q;

  assign tx = o_data[2*ADDR_W-1:ADDR_W];
  assign ty = o_data[ADDR_W-1:0];

  // X is resolved fully before Y is considered
  always_comb begin
    route = 5'b10000;
    if (tx > LX)      route = 5'b00001;
    else if (tx < LX) route = 5'b00010;
    else if (ty > LY) route = 5'b00100;
    else if (ty < LY) route = 5'b01000;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q | (i_rx & ~o_credit);
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    port_d  = port_q;
    rel_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          port_d  = route;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (i_grant) begin
          state_d = S_XFER;
          phase_d = P_HDR;
        end
      end
      S_XFER: begin
        if (pop) begin
          case (phase_q)
            P_HDR: phase_d = P_SIZE;
            P_SIZE: begin
              rem_d = o_data;
              if (o_data == '0) begin
                rel_d   = 1'b1;
                state_d = S_IDLE;
              end else begin
                phase_d = P_PAY;
              end
            end
            P_PAY: begin
              // leaving at rem==1 keeps rem from wrapping
              rem_d = rem_q - FLIT_W'(1);
              if (rem_q == FLIT_W'(1)) begin
                rel_d   = 1'b1;
                state_d = S_IDLE;
              end
            end
            default: phase_d = P_HDR;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      phase_q  <= P_HDR;
      rem_q    <= '0;
      port_q   <= '0;
      rel_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      phase_q  <= phase_d;
      rem_q    <= rem_d;
      port_q   <= port_d;
      rel_q    <= rel_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: tb/tb_router_input_port.sv
// Bench for router_input_port: flit scoreboard, XY route table,
// packet timing, overflow on a 4-deep port and mid-packet reset.
module tb_router_input_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b0;
  logic [15:0] din = '0;
  logic        credit, req, av, rel, ovf;
  logic [4:0]  port;
  logic        grant = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] dout;

  logic        rx2 = 1'b0;
  logic        grant2 = 1'b0;
  logic        ack2 = 1'b0;
  logic        credit2, req2, av2, rel2, ovf2;
  logic [4:0]  port2;
  logic [15:0] dout2;

  int total = 0;
  int bad = 0;
  int n_pop = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  router_input_port #(
    .FLIT_W(16), .DEPTH(8), .ADDR_W(4),
    .LOCAL_X(1), .LOCAL_Y(1)
  ) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_rx(rx), .i_data(din),
    .o_credit(credit), .o_req(req),
    .o_port(port), .i_grant(grant),
    .o_data_av(av), .o_data(dout),
    .i_data_ack(ack), .o_release(rel),
    .o_ovf(ovf)
  );

  router_input_port #(
    .FLIT_W(16), .DEPTH(4), .ADDR_W(4),
    .LOCAL_X(1), .LOCAL_Y(1)
  ) u_small (
    .i_clk(clk), .i_rst(rst),
    .i_rx(rx2), .i_data(din),
    .o_credit(credit2), .o_req(req2),
    .o_port(port2), .i_grant(grant2),
    .o_data_av(av2), .o_data(dout2),
    .i_data_ack(ack2), .o_release(rel2),
    .o_ovf(ovf2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] f);
    rx = 1'b1;
    din = f;
    sb_q.push_back(f);
    tick();
    rx = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req) break;
    end
    chk("req_seen", req, 1);
  endtask

  task automatic wait_rel(output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (rel) break;
    end
    chk("rel_seen", rel, 1);
  endtask

  task automatic grant_pulse();
    grant = 1'b1;
    tick();
    grant = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && av && ack) begin
      n_pop++;
      if (sb_q.size() == 0) chk("sb_under", sb_q.size(), 1);
      else chk("flit", dout, sb_q.pop_front());
    end
  end

  logic [15:0] hdr_t [5] = '{16'h0021, 16'h0001, 16'h0012,
                             16'h0010, 16'h0011};
  logic [4:0]  prt_t [5] = '{5'b00001, 5'b00010, 5'b00100,
                             5'b01000, 5'b10000};

  initial begin
    int cyc;
    int p0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_credit", credit, 1);
    chk("rst_req", req, 0);
    chk("rst_port", port, 0);
    chk("rst_av", av, 0);
    chk("rst_rel", rel, 0);
    chk("rst_ovf", ovf, 0);

    ack = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("ack_av", av, 0);
    chk("ack_credit", credit, 1);
    chk("ack_req", req, 0);
    chk("ack_rel", rel, 0);

    for (int i = 0; i < 5; i++) begin
      push(hdr_t[i]);
      @(negedge clk);
      chk("route_early", req, 0);
      push(16'h0000);
      @(negedge clk);
      chk("route_req", req, 1);
      chk("route_port", port, prt_t[i]);
      grant_pulse();
      wait_rel(cyc);
    end

    push(16'h0011);
    push(16'h0003);
    push(16'hA001);
    push(16'hA002);
    push(16'hA003);
    @(negedge clk);
    chk("s3_req", req, 1);
    chk("s3_port", port, 5'b10000);
    p0 = n_pop;
    grant_pulse();
    wait_rel(cyc);
    chk("s3_rel_cyc", cyc, 6);
    chk("s3_pops", n_pop - p0, 5);
    @(negedge clk);
    chk("s3_rel_pulse", rel, 0);
    chk("s3_idle_req", req, 0);
    chk("s3_idle_av", av, 0);

    push(16'h0021);
    push(16'h0000);
    push(16'h0001);
    push(16'h0000);
    @(negedge clk);
    chk("b2b_req_a", req, 1);
    chk("b2b_port_a", port, 5'b00001);
    grant_pulse();
    wait_rel(cyc);
    chk("b2b_rel_cyc", cyc, 3);
    @(negedge clk);
    chk("b2b_req_b", req, 1);
    chk("b2b_port_b", port, 5'b00010);
    grant_pulse();
    wait_rel(cyc);
    chk("b2b_empty", sb_q.size(), 0);

    for (int i = 0; i < 5; i++) begin
      rx2 = 1'b1;
      din = 16'h00A0 + 16'(i);
      tick();
      rx2 = 1'b0;
      @(negedge clk);
      chk("ovf_credit", credit2, (i < 3) ? 1 : 0);
      chk("ovf_flag", ovf2, (i == 4) ? 1 : 0);
    end
    grant2 = 1'b1;
    tick();
    grant2 = 1'b0;
    ack2 = 1'b1;
    @(negedge clk);
    chk("ovf_av", av2, 1);
    chk("ovf_head", dout2, 16'h00A0);
    tick();
    ack2 = 1'b0;
    @(negedge clk);
    chk("ovf_credit_back", credit2, 1);
    chk("ovf_sticky", ovf2, 1);
    chk("ovf_next", dout2, 16'h00A1);

    push(16'h0012);
    push(16'h0003);
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    wait_req();
    grant_pulse();
    tick();
    tick();
    rst = 1'b1;
    sb_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_av", av, 0);
    chk("mid_req", req, 0);
    chk("mid_credit", credit, 1);
    chk("mid_rel", rel, 0);
    chk("mid_ovf2", ovf2, 0);
    push(16'h0010);
    push(16'h0001);
    push(16'hBEEF);
    wait_req();
    chk("post_port", port, 5'b01000);
    grant_pulse();
    wait_rel(cyc);
    chk("post_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
